// File: rtl/i2c_m_arb.sv
`default_nettype none
// =====================================================================
// Module   : i2c_m_arb
// Purpose  : Round-robin arbiter sharing one I2C master between two
//            requesters, with start and busy watchdogs.
// Revision : 1.0 - initial release
// =====================================================================
module i2c_m_arb #(
    parameter int START_TO = 16,
    parameter int BUSY_TO  = 200000,
    parameter int CNT_W    = 18
) (
    input  logic        clk,
    input  logic        rstb,
    input  logic        req0_valid,
    input  logic        req0_rw,
    input  logic [6:0]  req0_adr,
    input  logic [31:0] req0_wr_data,
    input  logic [2:0]  req0_wr_bytes,
    input  logic [2:0]  req0_rd_bytes,
    output logic        req0_ack,
    output logic [31:0] req0_rd_data,
    output logic        req0_rd_data_en,
    output logic        req0_done,
    output logic        req0_err,
    input  logic        req1_valid,
    input  logic        req1_rw,
    input  logic [6:0]  req1_adr,
    input  logic [31:0] req1_wr_data,
    input  logic [2:0]  req1_wr_bytes,
    input  logic [2:0]  req1_rd_bytes,
    output logic        req1_ack,
    output logic [31:0] req1_rd_data,
    output logic        req1_rd_data_en,
    output logic        req1_done,
    output logic        req1_err,
    output logic        m_wr,
    output logic        m_rd,
    output logic [6:0]  m_adr,
    output logic [31:0] m_wr_data,
    output logic [2:0]  m_wr_bytes,
    output logic [2:0]  m_rd_bytes,
    input  logic [31:0] m_rd_data,
    input  logic        m_rd_data_en,
    input  logic        m_busy
);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_ISSUE      = 3'd1,
        S_WAIT_START = 3'd2,
        S_WAIT_DONE  = 3'd3,
        S_FINISH     = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] c_start_last = CNT_W'(START_TO - 1);
    localparam logic [CNT_W-1:0] c_busy_last  = CNT_W'(BUSY_TO - 1);

    state_t            r_state;
    logic              r_owner;
    logic              r_prio;
    logic              r_bto;
    logic [CNT_W-1:0]  r_cnt;

    logic              w_sel;
    logic              w_rw;
    logic [6:0]        w_adr;
    logic [31:0]       w_wr_data;
    logic [2:0]        w_wr_bytes;
    logic [2:0]        w_rd_bytes;
    logic              w_in_txn;

    // On a tie the priority pointer decides; otherwise the lone requester wins.
    always_comb begin
        w_sel      = (req0_valid && req1_valid) ? r_prio : req1_valid;
        w_rw       = w_sel ? req1_rw       : req0_rw;
        w_adr      = w_sel ? req1_adr      : req0_adr;
        w_wr_data  = w_sel ? req1_wr_data  : req0_wr_data;
        w_wr_bytes = w_sel ? req1_wr_bytes : req0_wr_bytes;
        w_rd_bytes = w_sel ? req1_rd_bytes : req0_rd_bytes;
        w_in_txn   = (r_state == S_WAIT_START) || (r_state == S_WAIT_DONE);
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_state         <= S_IDLE;
            r_owner         <= 1'b0;
            r_prio          <= 1'b0;
            r_bto           <= 1'b0;
            r_cnt           <= '0;
            req0_ack        <= 1'b0;
            req0_rd_data    <= '0;
            req0_rd_data_en <= 1'b0;
            req0_done       <= 1'b0;
            req0_err        <= 1'b0;
            req1_ack        <= 1'b0;
            req1_rd_data    <= '0;
            req1_rd_data_en <= 1'b0;
            req1_done       <= 1'b0;
            req1_err        <= 1'b0;
            m_wr            <= 1'b0;
            m_rd            <= 1'b0;
            m_adr           <= '0;
            m_wr_data       <= '0;
            m_wr_bytes      <= '0;
            m_rd_bytes      <= '0;
        end else begin
            m_wr            <= 1'b0;
            m_rd            <= 1'b0;
            req0_ack        <= 1'b0;
            req1_ack        <= 1'b0;
            req0_done       <= 1'b0;
            req1_done       <= 1'b0;
            req0_err        <= 1'b0;
            req1_err        <= 1'b0;
            req0_rd_data_en <= 1'b0;
            req1_rd_data_en <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (req0_valid || req1_valid) begin
                        r_owner    <= w_sel;
                        r_prio     <= ~w_sel;
                        m_adr      <= w_adr;
                        m_wr_data  <= w_wr_data;
                        m_wr_bytes <= w_wr_bytes;
                        m_rd_bytes <= w_rd_bytes;
                        m_wr       <= ~w_rw;
                        m_rd       <= w_rw;
                        req0_ack   <= ~w_sel;
                        req1_ack   <= w_sel;
                        r_state    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_cnt   <= '0;
                    r_state <= S_WAIT_START;
                end
                S_WAIT_START: begin
                    if (m_busy) begin
                        r_cnt   <= '0;
                        r_state <= S_WAIT_DONE;
                    end else if (r_cnt == c_start_last) begin
                        req0_done <= ~r_owner;
                        req1_done <= r_owner;
                        req0_err  <= ~r_owner;
                        req1_err  <= r_owner;
                        r_state   <= S_FINISH;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_WAIT_DONE: begin
                    if (!m_busy) begin
                        req0_done <= ~r_owner;
                        req1_done <= r_owner;
                        r_state   <= S_FINISH;
                    end else if (r_cnt == c_busy_last) begin
                        req0_done <= ~r_owner;
                        req1_done <= r_owner;
                        req0_err  <= ~r_owner;
                        req1_err  <= r_owner;
                        r_bto     <= 1'b1;
                        r_state   <= S_FINISH;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_FINISH: begin
                    // A hung master keeps us here so no new command overlaps it.
                    if (!(r_bto && m_busy)) begin
                        r_bto   <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            if (w_in_txn && m_rd_data_en) begin
                if (r_owner) begin
                    req1_rd_data_en <= 1'b1;
                    req1_rd_data    <= m_rd_data;
                end else begin
                    req0_rd_data_en <= 1'b1;
                    req0_rd_data    <= m_rd_data;
                end
            end
        end
    end

endmodule
`default_nettype wire
